pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the IF/ID and ID/EX pipeline registers.
// Registers one action per cycle (RUN, STALL, FLUSH) and tracks stall and flush statistics.
module pipe_stall_ctrl #(
  parameter int PC_W      = 64,
  parameter int CTRL_W    = 10,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hd_enable,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              pc_write,
  output logic [PC_W-1:0]   if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic [1:0]        state,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count,
  output logic              stall_timeout
);

  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } action_e;

  // The run counter must be able to hold MAX_STALL+1, its saturation value.
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);

  action_e           action;

  logic [PC_W-1:0]   if_id_pc_q,    if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q,  id_ex_ctrl_d;
  logic              id_ex_valid_q, id_ex_valid_d;
  action_e           state_q,       state_d;
  logic [RUN_W-1:0]  run_cnt_q,     run_cnt_d;
  logic [15:0]       stall_cnt_q,   stall_cnt_d;
  logic [15:0]       flush_cnt_q,   flush_cnt_d;
  logic              timeout_q,     timeout_d;

  // Flush wins over a simultaneous stall request.
  always_comb begin
    if (branch_taken)    action = ACT_FLUSH;
    else if (!hd_enable) action = ACT_STALL;
    else                 action = ACT_RUN;
  end

  // Reset cycles can never stall, so the PC keeps writing while reset is held.
  assign pc_write = reset || (action != ACT_STALL);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a variable unassigned (no latches).
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    id_ex_ctrl_d  = '0;
    id_ex_valid_d = 1'b0;
    state_d       = action;
    run_cnt_d     = '0;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    timeout_d     = timeout_q;

    unique case (action)
      ACT_RUN: begin
        if_id_pc_d    = if_pc;
        if_id_instr_d = if_instr;
        if_id_valid_d = 1'b1;
        id_ex_ctrl_d  = id_ctrl;
        id_ex_valid_d = 1'b1;
      end
      ACT_STALL: begin
        if (run_cnt_q == RUN_LIMIT) timeout_d = 1'b1;
        run_cnt_d = (run_cnt_q == RUN_SAT) ? RUN_SAT : run_cnt_q + 1'b1;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end
      ACT_FLUSH: begin
        if_id_pc_d    = '0;
        if_id_instr_d = '0;
        if_id_valid_d = 1'b0;
        if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      id_ex_ctrl_q  <= '0;
      id_ex_valid_q <= 1'b0;
      state_q       <= ACT_RUN;
      run_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      id_ex_valid_q <= id_ex_valid_d;
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign if_id_pc      = if_id_pc_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_valid   = if_id_valid_q;
  assign id_ex_ctrl    = id_ex_ctrl_q;
  assign id_ex_valid   = id_ex_valid_q;
  assign state         = state_q;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the pipeline rules.
module tb_pipe_stall_ctrl;
  localparam int PC_W      = 64;
  localparam int CTRL_W    = 10;
  localparam int MAX_STALL = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              hd_enable;
  logic              branch_taken;
  logic [PC_W-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic              pc_write;
  logic [PC_W-1:0]   if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_valid;
  logic [1:0]        state;
  logic [15:0]       stall_count;
  logic [15:0]       flush_count;
  logic              stall_timeout;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.PC_W(PC_W), .CTRL_W(CTRL_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .hd_enable(hd_enable), .branch_taken(branch_taken),
    .if_pc(if_pc), .if_instr(if_instr), .id_ctrl(id_ctrl), .pc_write(pc_write),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_ctrl(id_ex_ctrl), .id_ex_valid(id_ex_valid), .state(state),
    .stall_count(stall_count), .flush_count(flush_count), .stall_timeout(stall_timeout)
  );

  int tests_run = 0;
  int failed    = 0;

  // Reference model state.
  logic [PC_W-1:0]   m_pc;
  logic [31:0]       m_instr;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_exv;
  int                m_state;
  int                m_run;
  int                m_sc;
  int                m_fc;
  logic              m_to;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Action per cycle: 2 = flush, 1 = stall, 0 = run.
  function automatic int cur_action();
    if (branch_taken) return 2;
    if (!hd_enable)   return 1;
    return 0;
  endfunction

  function automatic logic exp_pc_write();
    return reset || (cur_action() != 1);
  endfunction

  function automatic void model_edge();
    int act;
    if (reset) begin
      m_pc = '0; m_instr = '0; m_valid = 0; m_ctrl = '0; m_exv = 0;
      m_state = 0; m_run = 0; m_sc = 0; m_fc = 0; m_to = 0;
      return;
    end
    act = cur_action();
    m_state = act;
    m_ctrl  = '0;
    m_exv   = 0;
    if (act == 0) begin
      m_pc = if_pc; m_instr = if_instr; m_valid = 1;
      m_ctrl = id_ctrl; m_exv = 1; m_run = 0;
    end else if (act == 1) begin
      if (m_run == MAX_STALL) m_to = 1;
      m_run = min_int(m_run + 1, MAX_STALL + 1);
      m_sc  = min_int(m_sc + 1, 65535);
    end else begin
      m_pc = '0; m_instr = '0; m_valid = 0; m_run = 0;
      m_fc = min_int(m_fc + 1, 65535);
    end
  endfunction

  task automatic drive(input logic rst, input logic hd, input logic br,
                       input logic [PC_W-1:0] pc, input logic [31:0] ins,
                       input logic [CTRL_W-1:0] ctl);
    reset = rst; hd_enable = hd; branch_taken = br;
    if_pc = pc; if_instr = ins; id_ctrl = ctl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    drive(1, 1, 0, '0, '0, '0);
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 64'hDEAD, 32'hBEEF, 10'h3FF);
    tick();
    tests_run++;
    if (pc_write !== 1'b1) begin failed++; $display("FAIL reset_pc_write got %b exp 1", pc_write); end
    tests_run++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== '0) begin
      failed++; $display("FAIL reset_if_id got %h/%h/%b exp 0", if_id_pc, if_id_instr, if_id_valid);
    end
    tests_run++;
    if ({id_ex_ctrl, id_ex_valid, state} !== '0) begin
      failed++; $display("FAIL reset_id_ex got %h/%b/%0d exp 0", id_ex_ctrl, id_ex_valid, state);
    end
    tests_run++;
    if ({stall_count, flush_count, stall_timeout} !== '0) begin
      failed++; $display("FAIL reset_counters got %h/%h/%b exp 0", stall_count, flush_count, stall_timeout);
    end
    reset = 0;
  endtask

  task automatic test_run();
    do_reset();
    drive(0, 1, 0, 64'h100, 32'h8B020020, 10'h155);
    #1;
    tests_run++;
    if (pc_write !== 1'b1) begin failed++; $display("FAIL run_pc_write got %b exp 1", pc_write); end
    tick();
    tests_run++;
    if (if_id_pc !== 64'h100 || if_id_instr !== 32'h8B020020 || if_id_valid !== 1'b1) begin
      failed++; $display("FAIL run_if_id got %h/%h/%b exp 100/8b020020/1", if_id_pc, if_id_instr, if_id_valid);
    end
    tests_run++;
    if (id_ex_ctrl !== 10'h155 || id_ex_valid !== 1'b1 || state !== 2'd0) begin
      failed++; $display("FAIL run_id_ex got %h/%b/%0d exp 155/1/0", id_ex_ctrl, id_ex_valid, state);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 1, 0, 64'h200, 32'h12345678, 10'h0AA);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 64'h204 + 64'(4 * i), 32'hCAFE0000 + i, 10'h3C3);
      #1;
      tests_run++;
      if (pc_write !== 1'b0) begin failed++; $display("FAIL stall_pc_write cyc %0d got %b exp 0", i, pc_write); end
      tick();
      tests_run++;
      if (if_id_pc !== 64'h200 || if_id_instr !== 32'h12345678 || if_id_valid !== 1'b1) begin
        failed++; $display("FAIL stall_hold cyc %0d got %h/%h/%b exp 200/12345678/1", i, if_id_pc, if_id_instr, if_id_valid);
      end
      tests_run++;
      if (id_ex_ctrl !== '0 || id_ex_valid !== 1'b0 || state !== 2'd1) begin
        failed++; $display("FAIL stall_bubble cyc %0d got %h/%b/%0d exp 0/0/1", i, id_ex_ctrl, id_ex_valid, state);
      end
    end
    tests_run++;
    if (stall_count !== 16'd2) begin failed++; $display("FAIL stall_count got %0d exp 2", stall_count); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    drive(0, 1, 0, 64'h300, 32'h11112222, 10'h011);
    tick();
    drive(0, 0, 1, 64'h304, 32'h33334444, 10'h022);
    #1;
    tests_run++;
    if (pc_write !== 1'b1) begin failed++; $display("FAIL flush_pc_write got %b exp 1", pc_write); end
    tick();
    tests_run++;
    if (if_id_valid !== 1'b0 || if_id_pc !== '0 || if_id_instr !== '0 || state !== 2'd2) begin
      failed++; $display("FAIL flush_if_id got %h/%h/%b/%0d exp 0/0/0/2", if_id_pc, if_id_instr, if_id_valid, state);
    end
    tests_run++;
    if (flush_count !== 16'd1 || stall_count !== 16'd0 || id_ex_valid !== 1'b0) begin
      failed++; $display("FAIL flush_counts got fc=%0d sc=%0d exv=%b exp 1/0/0", flush_count, stall_count, id_ex_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, '0, '0, '0);
      tick();
      tests_run++;
      if (stall_timeout !== (i == 4)) begin
        failed++; $display("FAIL timeout_after_stall %0d got %b exp %b", i, stall_timeout, (i == 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 64'(i), 32'(i), 10'(i));
      tick();
    end
    tests_run++;
    if (stall_timeout !== 1'b1) begin failed++; $display("FAIL timeout_sticky got %b exp 1", stall_timeout); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(0, 1, 0, 64'h500, 32'h55555555, 10'h155);
    tick();
    drive(0, 0, 0, 64'h504, 32'h66666666, 10'h0F0);
    tick();
    tick();
    drive(1, 0, 0, 64'h508, 32'h77777777, 10'h0F0);
    #1;
    tests_run++;
    if (pc_write !== 1'b1) begin failed++; $display("FAIL rst_mid_pc_write got %b exp 1", pc_write); end
    tick();
    tests_run++;
    if ({if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid, state} !== '0 ||
        {stall_count, flush_count, stall_timeout} !== '0) begin
      failed++; $display("FAIL rst_mid_state got pc=%h v=%b st=%0d sc=%0d", if_id_pc, if_id_valid, state, stall_count);
    end
    tests_run++;
    if (pc_write !== 1'b1) begin failed++; $display("FAIL rst_mid_pc_write_held got %b exp 1", pc_write); end
    reset = 0;
  endtask

  task automatic test_stall_saturation();
    do_reset();
    drive(0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 65534; i++) tick();
    tests_run++;
    if (stall_count !== 16'hFFFE) begin failed++; $display("FAIL sat_preload got %h exp fffe", stall_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (stall_count !== 16'hFFFF) begin failed++; $display("FAIL sat_hold step %0d got %h exp ffff", i, stall_count); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
            {$urandom, $urandom}, $urandom, CTRL_W'($urandom));
      #1;
      tests_run++;
      if (pc_write !== exp_pc_write()) begin
        failed++; $display("FAIL rand_pc_write cyc %0d got %b exp %b", i, pc_write, exp_pc_write());
      end
      tick();
      tests_run++;
      if (if_id_pc !== m_pc || if_id_instr !== m_instr || if_id_valid !== m_valid) begin
        failed++; $display("FAIL rand_if_id cyc %0d got %h/%h/%b exp %h/%h/%b", i,
                           if_id_pc, if_id_instr, if_id_valid, m_pc, m_instr, m_valid);
      end
      tests_run++;
      if (id_ex_ctrl !== m_ctrl || id_ex_valid !== m_exv || state !== 2'(m_state)) begin
        failed++; $display("FAIL rand_id_ex cyc %0d got %h/%b/%0d exp %h/%b/%0d", i,
                           id_ex_ctrl, id_ex_valid, state, m_ctrl, m_exv, m_state);
      end
      tests_run++;
      if (stall_count !== 16'(m_sc) || flush_count !== 16'(m_fc) || stall_timeout !== m_to) begin
        failed++; $display("FAIL rand_counters cyc %0d got %0d/%0d/%b exp %0d/%0d/%b", i,
                           stall_count, flush_count, stall_timeout, m_sc, m_fc, m_to);
      end
    end
    reset = 0;
  endtask

  initial begin
    drive(1, 1, 0, '0, '0, '0);
    test_reset();
    test_run();
    test_stall();
    test_flush_priority();
    test_timeout();
    test_reset_mid_stall();
    test_random();
    test_stall_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
